tx_status_arbiter: RTL and testbench
====================================

# tx_status_arbiter

Round-robin arbiter and write sequencer for the 64-deep tx status FIFO. It accepts tx-completion reports from the four tx queue paths, serialises them onto the single FIFO write port, and packs each report into the 19-bit status word. It also raises a coalesced interrupt to the ARM when the driver should drain the FIFO. It sits between the per-queue tx completion logic and the status FIFO in tx_intf.

## Interface
- Parameters: none.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- req  in  4  per-queue report request; level-held until the matching ack.
- req_status  in  20  4×5-bit tx status; queue i uses bits [5i+4:5i].
- req_sn  in  40  4×10-bit packet SN; queue i uses bits [10i+9:10i].
- req_prio  in  8  4×2-bit linux_prio; queue i uses bits [2i+1:2i].
- ack  out  4  one-cycle grant/consume pulse per queue.
- fifo_full  in  1  status FIFO full.
- fifo_wren  out  1  FIFO write enable; one-cycle pulse.
- fifo_di  out  19  {linux_prio[1:0], queue_idx[1:0], pkt_sn[9:0], status[4:0]}.
- irq_cnt_thresh  in  6  coalesce count threshold; 0 is treated as 1.
- irq_timeout  in  16  coalesce timeout in clk cycles; 0 disables the timeout.
- tx_status_irq  out  1  one-cycle interrupt pulse.
- stall_cnt  out  16  saturating count of cycles with any req high while fifo_full=1.

## Operation
- FSM states:
  - IDLE: if any req bit is high and fifo_full=0, select the winner and go to GRANT. Otherwise stay in IDLE.
  - GRANT: fifo_wren=1, ack[winner]=1, then return to IDLE unconditionally.
- Arbitration is round-robin. Search order starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, … mod 4. After each grant, rr_ptr ← winner+1 (mod 4). Reset value of rr_ptr is 0.
- fifo_di is registered at the IDLE→GRANT edge from the winner's fields, with queue_idx = winner index.
- Requester rule: fields stay stable while req is high; req drops in the cycle after ack. A req that is still high one cycle after its ack is treated as a new report.
- fifo_full is sampled only in IDLE. A report is never dropped; it waits.
- stall_cnt increments each cycle in which |req=1 and fifo_full=1, and saturates at 0xFFFF.
- Interrupt bookkeeping:
  - unrep_cnt (7 bit) increments on every fifo_wren.
  - age_cnt (16 bit) increments each cycle while unrep_cnt>0 and holds at 0 otherwise.
  - Fire tx_status_irq when unrep_cnt+wren ≥ max(thresh,1), or when irq_timeout≠0 and age_cnt = irq_timeout−1 with unrep_cnt>0.
  - On fire, unrep_cnt and age_cnt clear. A write in the fire cycle counts toward the next interval (unrep_cnt←1).
- Reset values: ack=0, fifo_wren=0, fifo_di=0, tx_status_irq=0, stall_cnt=0, state=IDLE, unrep_cnt=0, age_cnt=0.
- Reset mid-GRANT: the write is abandoned (wren=0 from the next cycle). The requester keeps req high and the report is retried after reset.

## Timing
- req high in cycle N (IDLE, not full) → fifo_wren, ack and fifo_di valid in cycle N+1.
- Peak throughput is one write per 2 cycles.
- Count-triggered irq is asserted in the cycle after the threshold-reaching write (registered).
- Timeout irq is asserted irq_timeout cycles after the first unreported write.
- Simultaneous count and timeout triggers produce a single pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- TX_STATUS_IRQ_COALESCE_EN defined: coalescing as described above.
- TX_STATUS_IRQ_COALESCE_EN undefined:
  - tx_status_irq is a registered copy of fifo_wren (one pulse per write).
  - irq_cnt_thresh and irq_timeout are ignored.
  - unrep_cnt and age_cnt are not built.

## Test plan
- Single report: req=4'b0100, sn=0x155, status=0x1A, prio=2, fifo_full=0.
  - Expect one wren one cycle later with fifo_di={2'd2,2'd2,10'h155,5'h1A}, ack=4'b0100.
- All four requests held high from reset: grants in order 0,1,2,3,0,…
  - One wren every 2 cycles; each queue is acked exactly once per 8 cycles.
- Backpressure: fifo_full=1 for 10 cycles with req[1] high.
  - No wren or ack during that time; stall_cnt=10.
  - Write follows 1 cycle after full drops.
- Coalescing (macro on): thresh=4, timeout=0, 4 reports.
  - Exactly one irq pulse, in the cycle after the 4th wren.
- Coalescing timeout: thresh=8, timeout=100, 1 report.
  - irq exactly 100 cycles after the wren; unrep_cnt=0 afterwards.
- Macro off: 3 reports → 3 irq pulses, each one cycle after its wren.

Source files
------------

// File: rtl/tx_status_arbiter.sv
// Round-robin arbiter and write sequencer for the tx status FIFO, with interrupt generation.
// Optional coalescing of tx_status_irq is enabled by defining TX_STATUS_IRQ_COALESCE_EN.
module tx_status_arbiter (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  req,
    input  logic [19:0] req_status,
    input  logic [39:0] req_sn,
    input  logic [7:0]  req_prio,
    output logic [3:0]  ack,
    input  logic        fifo_full,
    output logic        fifo_wren,
    output logic [18:0] fifo_di,
    input  logic [5:0]  irq_cnt_thresh,
    input  logic [15:0] irq_timeout,
    output logic        tx_status_irq,
    output logic [15:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_grant_go;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  w_winner;
    logic [4:0]  w_win_status;
    logic [9:0]  w_win_sn;
    logic [1:0]  w_win_prio;
    logic [3:0]  r_ack;
    logic        r_wren;
    logic [18:0] r_di;
    logic        r_irq;
    logic [15:0] r_stall_cnt;

    // First requester at or after ptr, walking upward modulo 4.
    function automatic logic [1:0] f_rr_pick(input logic [3:0] req_v, input logic [1:0] ptr);
        logic [1:0] idx;
        f_rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx       = ptr + 2'(k);
            f_rr_pick = req_v[idx] ? idx : f_rr_pick;
        end
    endfunction

    assign w_winner = f_rr_pick(req, r_rr_ptr);

    always_comb begin
        w_win_status = 5'd0;
        w_win_sn     = 10'd0;
        w_win_prio   = 2'd0;
        case (w_winner)
            2'd0: begin
                w_win_status = req_status[4:0];
                w_win_sn     = req_sn[9:0];
                w_win_prio   = req_prio[1:0];
            end
            2'd1: begin
                w_win_status = req_status[9:5];
                w_win_sn     = req_sn[19:10];
                w_win_prio   = req_prio[3:2];
            end
            2'd2: begin
                w_win_status = req_status[14:10];
                w_win_sn     = req_sn[29:20];
                w_win_prio   = req_prio[5:4];
            end
            2'd3: begin
                w_win_status = req_status[19:15];
                w_win_sn     = req_sn[39:30];
                w_win_prio   = req_prio[7:6];
            end
            default: begin
                w_win_status = 5'd0;
                w_win_sn     = 10'd0;
                w_win_prio   = 2'd0;
            end
        endcase
    end

    // fifo_full only matters in IDLE; a GRANT always completes in one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_go  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|req) && !fifo_full) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_go  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant outputs are loaded on the IDLE->GRANT edge so they are high exactly in GRANT.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ack    <= 4'b0000;
            r_wren   <= 1'b0;
            r_di     <= 19'd0;
            r_rr_ptr <= 2'd0;
        end else begin
            r_ack  <= w_grant_go ? (4'b0001 << w_winner) : 4'b0000;
            r_wren <= w_grant_go;
            if (w_grant_go) begin
                r_di     <= {w_win_prio, w_winner, w_win_sn, w_win_status};
                r_rr_ptr <= w_winner + 2'd1;
            end else begin
                r_di     <= r_di;
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall_cnt <= 16'd0;
        end else if ((|req) && fifo_full && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

`ifdef TX_STATUS_IRQ_COALESCE_EN
    logic [6:0]  r_unrep_cnt;
    logic [15:0] r_age_cnt;
    logic [5:0]  w_thresh_eff;
    logic [6:0]  w_cnt_sum;
    logic        w_pending;
    logic        w_fire_cnt;
    logic        w_fire_to;
    logic        w_carry;

    // age_cnt counts cycles since the oldest unreported write, so the timeout
    // compare against irq_timeout-1 lands the registered pulse irq_timeout cycles later.
    always_comb begin
        w_thresh_eff = (irq_cnt_thresh == 6'd0) ? 6'd1 : irq_cnt_thresh;
        w_cnt_sum    = r_unrep_cnt + {6'd0, r_wren};
        w_pending    = (r_unrep_cnt != 7'd0) || r_wren;
        w_fire_cnt   = (w_cnt_sum >= {1'b0, w_thresh_eff});
        w_fire_to    = (irq_timeout != 16'd0) && w_pending && (r_age_cnt == (irq_timeout - 16'd1));
        w_carry      = r_wren && (r_unrep_cnt != 7'd0);
    end

    // A write landing on a timeout fired by older writes opens the next interval.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_unrep_cnt <= 7'd0;
            r_age_cnt   <= 16'd0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= w_fire_cnt || w_fire_to;
            if (w_fire_cnt) begin
                r_unrep_cnt <= 7'd0;
                r_age_cnt   <= 16'd0;
            end else if (w_fire_to) begin
                r_unrep_cnt <= w_carry ? 7'd1 : 7'd0;
                r_age_cnt   <= w_carry ? 16'd1 : 16'd0;
            end else begin
                r_unrep_cnt <= w_cnt_sum;
                r_age_cnt   <= w_pending ? (r_age_cnt + 16'd1) : 16'd0;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{irq_cnt_thresh, irq_timeout};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_wren;
        end
    end
`endif

    assign ack           = r_ack;
    assign fifo_wren     = r_wren;
    assign fifo_di       = r_di;
    assign tx_status_irq = r_irq;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_tx_status_arbiter.sv
// Scoreboard bench for tx_status_arbiter: directed stimulus pushes expected writes/irqs,
// a negedge monitor pops and compares whenever the DUT presents a write or an interrupt.
module tb_tx_status_arbiter;

`ifdef TX_STATUS_IRQ_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [19:0] req_status;
    logic [39:0] req_sn;
    logic [7:0]  req_prio;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_wren;
    logic [18:0] fifo_di;
    logic [5:0]  irq_cnt_thresh;
    logic [15:0] irq_timeout;
    logic        tx_status_irq;
    logic [15:0] stall_cnt;

    typedef struct {
        logic [18:0] di;
        logic [3:0]  ack;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   irq_q[$];
    int   cyc;
    int   n_chk;
    int   n_fail;

    tx_status_arbiter dut (
        .clk            (clk),
        .rstn           (rstn),
        .req            (req),
        .req_status     (req_status),
        .req_sn         (req_sn),
        .req_prio       (req_prio),
        .ack            (ack),
        .fifo_full      (fifo_full),
        .fifo_wren      (fifo_wren),
        .fifo_di        (fifo_di),
        .irq_cnt_thresh (irq_cnt_thresh),
        .irq_timeout    (irq_timeout),
        .tx_status_irq  (tx_status_irq),
        .stall_cnt      (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [18:0] mk_di(input logic [1:0] pr, input logic [1:0] q,
                                          input logic [9:0] sn, input logic [4:0] st);
        return {pr, q, sn, st};
    endfunction

    task automatic push_wr(input logic [18:0] di, input int q, input int at_cyc);
        exp_t e;
        e.di  = di;
        e.ack = 4'b0001 << q;
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write/ack or irq pulse must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (fifo_wren || (ack != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {13'd0, fifo_wren, ack, 14'd0}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("fifo_wren", {31'd0, fifo_wren}, 32'd1);
                chk("fifo_di", {13'd0, fifo_di}, {13'd0, e.di});
                chk("ack", {28'd0, ack}, {28'd0, e.ack});
            end
        end
        if (tx_status_irq) begin
            if (irq_q.size() == 0) begin
                chk("unexpected_irq", cyc, 32'hFFFFFFFF);
            end else begin
                chk("irq_cycle", cyc, irq_q.pop_front());
            end
        end
    end

    // Raise one report, wait (bounded) for its ack, then drop req as a requester would.
    task automatic issue(input int q, input logic [9:0] sn, input logic [4:0] st,
                         input logic [1:0] pr, input int irq_dly);
        bit seen;
        req_sn[10*q +: 10]   = sn;
        req_status[5*q +: 5] = st;
        req_prio[2*q +: 2]   = pr;
        push_wr(mk_di(pr, 2'(q), sn, st), q, cyc + 1);
        if (irq_dly > 0) irq_q.push_back(cyc + irq_dly);
        req[q] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (ack[q]) seen = 1'b1;
        end
        req[q] = 1'b0;
        chk("ack_wait", {31'd0, seen}, 32'd1);
        tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        int c;
        int nacks;
        bit seen;
        cyc            = 0;
        n_chk          = 0;
        n_fail         = 0;
        rstn           = 1'b0;
        fifo_full      = 1'b0;
        irq_cnt_thresh = 6'd63;
        irq_timeout    = 16'd0;
        req_status     = 20'd0;
        req_sn         = 40'd0;
        req_prio       = 8'd0;
        for (int i = 0; i < 4; i++) begin
            req_sn[10*i +: 10]   = 10'h100 + 10'(i);
            req_status[5*i +: 5] = 5'(i + 1);
            req_prio[2*i +: 2]   = 2'(3 - i);
        end
        req = 4'hF;

        // Reset values, with all four requests already held.
        tick();
        tick();
        tick();
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_wren", {31'd0, fifo_wren}, 32'd0);
        chk("rst_di", {13'd0, fifo_di}, 32'd0);
        chk("rst_irq", {31'd0, tx_status_irq}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);

        // All four held from reset: grants 0,1,2,3,0,1,2,3, one write every 2 cycles.
        rstn = 1'b1;
        c = cyc;
        for (int k = 0; k < 8; k++) begin
            push_wr(mk_di(2'(3 - (k % 4)), 2'(k % 4), 10'h100 + 10'(k % 4), 5'((k % 4) + 1)),
                    k % 4, c + 1 + 2 * k);
            if (!COALESCE) irq_q.push_back(c + 2 + 2 * k);
        end
        nacks = 0;
        for (int t = 0; t < 40 && nacks < 8; t++) begin
            tick();
            if (ack != 4'b0000) nacks = nacks + 1;
        end
        req = 4'h0;
        chk("four_acks", nacks, 8);
        tick();
        tick();

        // Single report on queue 2; hand-packed word {2,2,0x155,0x1A}.
        req_sn[29:20]     = 10'h155;
        req_status[14:10] = 5'h1A;
        req_prio[5:4]     = 2'd2;
        c = cyc;
        push_wr(19'h52ABA, 2, c + 1);
        if (!COALESCE) irq_q.push_back(c + 2);
        req[2] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (ack[2]) seen = 1'b1;
        end
        req[2] = 1'b0;
        chk("single_ack_wait", {31'd0, seen}, 32'd1);
        tick();
        tick();

        // Backpressure: 10 full cycles with req[1], then the write one cycle after full drops.
        fifo_full     = 1'b1;
        req_sn[19:10] = 10'h2A5;
        req_status[9:5] = 5'h03;
        req_prio[3:2] = 2'd1;
        c = cyc;
        push_wr(19'h2D4A3, 1, c + 11);
        if (!COALESCE) irq_q.push_back(c + 12);
        req[1] = 1'b1;
        for (int t = 0; t < 10; t++) tick();
        chk("stall_cnt_10", {16'd0, stall_cnt}, 32'd10);
        fifo_full = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (ack[1]) seen = 1'b1;
        end
        req[1] = 1'b0;
        chk("bp_ack_wait", {31'd0, seen}, 32'd1);
        tick();
        chk("stall_cnt_hold", {16'd0, stall_cnt}, 32'd10);
        tick();

`ifdef TX_STATUS_IRQ_COALESCE_EN
        // Count trigger: thresh=4, 4 reports, one pulse the cycle after the 4th write.
        irq_cnt_thresh = 6'd4;
        irq_timeout    = 16'd0;
        do_reset();
        tick();
        issue(0, 10'h011, 5'h01, 2'd0, 0);
        issue(1, 10'h022, 5'h02, 2'd1, 0);
        issue(2, 10'h033, 5'h03, 2'd2, 0);
        issue(3, 10'h044, 5'h04, 2'd3, 2);
        for (int t = 0; t < 10; t++) tick();
        chk("unrep_after_cnt", {25'd0, dut.r_unrep_cnt}, 32'd0);

        // Timeout trigger: thresh=8, timeout=100, single report.
        irq_cnt_thresh = 6'd8;
        irq_timeout    = 16'd100;
        issue(3, 10'h3FF, 5'h1F, 2'd3, 101);
        for (int t = 0; t < 110; t++) tick();
        chk("unrep_after_to", {25'd0, dut.r_unrep_cnt}, 32'd0);
        for (int t = 0; t < 120; t++) tick();
`else
        // Non-coalesced: each write produces its own irq one cycle later.
        issue(0, 10'h011, 5'h01, 2'd0, 2);
        issue(3, 10'h2C3, 5'h15, 2'd1, 2);
        issue(1, 10'h0F0, 5'h0A, 2'd3, 2);
`endif

        for (int t = 0; t < 5; t++) tick();
        chk("wr_queue_drained", exp_q.size(), 0);
        chk("irq_queue_drained", irq_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
